// File: rtl/serpent_enc_iter.sv
// Iterative Serpent-128 encryption core.
// A single round datapath (key mix, bitsliced S-box, linear transform) is
// reused for NROUNDS rounds, then one extra cycle applies the final
// whitening key. Round keys are fetched by index from an external store.
module serpent_enc_iter #(
  parameter int unsigned NROUNDS = 32,
  parameter int unsigned KIDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      pt_in,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [127:0]      round_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      ct_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  localparam logic [KIDX_W-1:0] LAST_SBOX = KIDX_W'(NROUNDS - 1);
  localparam logic [KIDX_W-1:0] FINAL_KEY = KIDX_W'(NROUNDS);

  fsm_t              fsm_q;
  fsm_t              fsm_d;
  logic [KIDX_W-1:0] rnd_q;
  logic [127:0]      blk_q;
  logic [127:0]      ct_q;

  logic [127:0]      mixed;
  logic [127:0]      sboxed;
  logic [127:0]      lt_out;

  // S-box n packed as 16 nibbles, entry v at bits [4v+3:4v].
  function automatic logic [63:0] sbox_row(input logic [2:0] sel);
    logic [63:0] t;
    t = '0;
    unique case (sel)
      3'd0: t = 64'hC90724DEB56A1F83;
      3'd1: t = 64'h43D68EB1A50972CF;
      3'd2: t = 64'h25B04E1DFAC39768;
      3'd3: t = 64'hE57A421D369C8BF0;
      3'd4: t = 64'hD7E9A4526B0C38F1;
      3'd5: t = 64'h176D8E30C9A4B25F;
      3'd6: t = 64'h0A3DF19EB6485C27;
      3'd7: t = 64'h6539AC47B28E0FD1;
    endcase
    return t;
  endfunction

  // Bit j of each word forms one nibble {x3,x2,x1,x0}; x0 is the LSB.
  function automatic logic [127:0] sbox_apply(input logic [127:0] x,
                                              input logic [2:0]   sel);
    logic [63:0]  tab;
    logic [3:0]   nib;
    logic [3:0]   y;
    logic [127:0] r;
    tab = sbox_row(sel);
    r   = '0;
    for (int unsigned j = 0; j < 32; j++) begin
      nib        = {x[96+j], x[64+j], x[32+j], x[j]};
      y          = tab[{nib, 2'b00} +: 4];
      r[j]       = y[0];
      r[32+j]    = y[1];
      r[64+j]    = y[2];
      r[96+j]    = y[3];
    end
    return r;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x,
                                       input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] lin_xform(input logic [127:0] s);
    logic [31:0] x0, x1, x2, x3;
    x0 = s[31:0];
    x1 = s[63:32];
    x2 = s[95:64];
    x3 = s[127:96];
    x0 = rotl(x0, 13);
    x2 = rotl(x2, 3);
    x1 = x1 ^ x0 ^ x2;
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rotl(x1, 1);
    x3 = rotl(x3, 7);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rotl(x0, 5);
    x2 = rotl(x2, 22);
    return {x3, x2, x1, x0};
  endfunction

  // Round datapath; S-box index is rnd mod 8.
  always_comb begin
    mixed  = blk_q ^ round_key;
    sboxed = sbox_apply(mixed, rnd_q[2:0]);
    lt_out = lin_xform(sboxed);
  end

  // Next-state decode for the block FSM.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE: if (in_valid) fsm_d = RUN;
      RUN:  if (rnd_q == FINAL_KEY) fsm_d = DONE;
      DONE: if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // State, round counter and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      rnd_q <= '0;
      blk_q <= '0;
      ct_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      unique case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            blk_q <= pt_in;
            rnd_q <= '0;
          end
        end
        RUN: begin
          if (rnd_q == FINAL_KEY) begin
            ct_q <= mixed;
          end else begin
            blk_q <= (rnd_q == LAST_SBOX) ? sboxed : lt_out;
            rnd_q <= rnd_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign busy      = (fsm_q == RUN);
  assign out_valid = (fsm_q == DONE);
  assign key_idx   = (fsm_q == RUN) ? rnd_q : '0;
  assign ct_out    = ct_q;

endmodule

// File: tb/tb_serpent_enc_iter.sv
// Bench for serpent_enc_iter: full-round and 8-round instances, a reference
// cipher/decipher model and a queue of expected ciphertexts.
module tb_serpent_enc_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] pt_in = '0;

  logic         in_valid32 = 1'b0, out_ready32 = 1'b1;
  logic         in_ready32, out_valid32, busy32;
  logic [5:0]   key_idx32;
  logic [127:0] round_key32, ct_out32;

  logic         in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic         in_ready8, out_valid8, busy8;
  logic [5:0]   key_idx8;
  logic [127:0] round_key8, ct_out8;

  logic [127:0] keys32 [64];
  logic [127:0] keys8  [64];

  int unsigned  checks = 0;
  int unsigned  fails  = 0;
  int unsigned  cyc    = 0;
  logic [127:0] exp_q [$];
  logic [127:0] last_exp;

  int unsigned sb [8][16] = '{
    '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
    '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
    '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
    '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
    '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
    '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
    '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
    '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
  };
  int unsigned isb [8][16];

  assign round_key32 = keys32[key_idx32];
  assign round_key8  = keys8[key_idx8];

  serpent_enc_iter #(.NROUNDS(32), .KIDX_W(6)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .pt_in(pt_in), .key_idx(key_idx32), .round_key(round_key32),
    .out_valid(out_valid32), .out_ready(out_ready32), .ct_out(ct_out32),
    .busy(busy32)
  );

  serpent_enc_iter #(.NROUNDS(8), .KIDX_W(6)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .pt_in(pt_in), .key_idx(key_idx8), .round_key(round_key8),
    .out_valid(out_valid8), .out_ready(out_ready8), .ct_out(ct_out8),
    .busy(busy8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rol(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [127:0] m_sbox(input logic [127:0] s,
                                          input int unsigned box, input bit inv);
    logic [127:0] r;
    logic [3:0]   nib;
    logic [3:0]   o;
    r = '0;
    for (int j = 0; j < 32; j++) begin
      nib = {s[96+j], s[64+j], s[32+j], s[j]};
      o   = inv ? 4'(isb[box][nib]) : 4'(sb[box][nib]);
      r[j] = o[0]; r[32+j] = o[1]; r[64+j] = o[2]; r[96+j] = o[3];
    end
    return r;
  endfunction

  function automatic logic [127:0] m_lt(input logic [127:0] s);
    logic [31:0] a, b, c, d;
    {d, c, b, a} = s;
    a = rol(a, 13); c = rol(c, 3);
    b = b ^ a ^ c;  d = d ^ c ^ (a << 3);
    b = rol(b, 1);  d = rol(d, 7);
    a = a ^ b ^ d;  c = c ^ d ^ (b << 7);
    a = rol(a, 5);  c = rol(c, 22);
    return {d, c, b, a};
  endfunction

  function automatic logic [127:0] m_ilt(input logic [127:0] s);
    logic [31:0] a, b, c, d;
    {d, c, b, a} = s;
    c = ror(c, 22); a = ror(a, 5);
    c = c ^ d ^ (b << 7); a = a ^ b ^ d;
    d = ror(d, 7);  b = ror(b, 1);
    d = d ^ c ^ (a << 3); b = b ^ a ^ c;
    c = ror(c, 3);  a = ror(a, 13);
    return {d, c, b, a};
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt,
                                             input int unsigned nr,
                                             input logic [127:0] k [64]);
    logic [127:0] s;
    s = pt;
    for (int unsigned r = 0; r < nr; r++) begin
      s = m_sbox(s ^ k[r], r % 8, 1'b0);
      if (r < nr - 1) s = m_lt(s);
    end
    return s ^ k[nr];
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct,
                                             input int unsigned nr,
                                             input logic [127:0] k [64]);
    logic [127:0] s;
    s = m_sbox(ct ^ k[nr], 7, 1'b1) ^ k[nr-1];
    for (int r = int'(nr) - 2; r >= 0; r--) begin
      s = m_sbox(m_ilt(s), 32'(r) % 8, 1'b1) ^ k[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_keys32();
    for (int i = 0; i < 64; i++) keys32[i] = rand128();
  endtask

  // Offer one block to the 32-round core and wait for its output cycle.
  // Leaves the bench at the first out_valid cycle; the caller owns out_ready.
  task automatic send32(input logic [127:0] pt, input bit timing,
                        output int unsigned waited);
    logic [127:0] exp;
    waited = 0;
    while (!in_ready32 && waited < 100) begin
      tick();
      waited++;
    end
    checks++;
    if (in_ready32 !== 1'b1) begin
      fails++;
      $display("FAIL send_ready_timeout: in_ready=%b required 1", in_ready32);
      return;
    end
    pt_in = pt;
    in_valid32 = 1'b1;
    exp_q.push_back(model_enc(pt, 32, keys32));
    tick();
    in_valid32 = 1'b0;
    pt_in = rand128();
    if (timing) begin
      for (int c = 0; c <= 32; c++) begin
        checks++;
        if ({busy32, out_valid32, in_ready32, key_idx32} !== {1'b1, 1'b0, 1'b0, 6'(c)}) begin
          fails++;
          $display("FAIL run_cycle_%0d: busy/ov/ir/kidx=%b/%b/%b/%0d required 1/0/0/%0d",
                   c, busy32, out_valid32, in_ready32, key_idx32, c);
        end
        tick();
      end
    end else begin
      repeat (33) tick();
    end
    checks++;
    if (out_valid32 !== 1'b1) begin
      fails++;
      $display("FAIL out_valid_latency: out_valid=%b required 1 at T+34", out_valid32);
    end
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    last_exp = exp;
    checks++;
    if (ct_out32 !== exp) begin
      fails++;
      $display("FAIL ciphertext: got %h required %h", ct_out32, exp);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      in_valid32 = 1'($urandom); in_valid8 = 1'($urandom);
      out_ready32 = 1'($urandom); out_ready8 = 1'($urandom);
      pt_in = rand128();
      tick();
    end
    rst = 1'b0;
    in_valid32 = 1'b0; in_valid8 = 1'b0;
    out_ready32 = 1'b1; out_ready8 = 1'b1;
    checks++;
    if (in_ready32 !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready32); end
    checks++;
    if (out_valid32 !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid32); end
    checks++;
    if (busy32 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy32); end
    checks++;
    if (key_idx32 !== 6'd0) begin fails++; $display("FAIL reset_key_idx: got %0d required 0", key_idx32); end
    checks++;
    if (ct_out32 !== 128'd0) begin fails++; $display("FAIL reset_ct_out: got %h required 0", ct_out32); end
    checks++;
    if ({in_ready8, out_valid8, busy8} !== 3'b100) begin
      fails++; $display("FAIL reset_dut8: ir/ov/busy=%b%b%b required 100", in_ready8, out_valid8, busy8);
    end
  endtask

  task automatic test_single_block();
    int unsigned w;
    randomize_keys32();
    out_ready32 = 1'b1;
    send32(128'd0, 1'b1, w);
    tick();
    checks++;
    if ({out_valid32, in_ready32} !== 2'b01) begin
      fails++; $display("FAIL single_release: ov/ir=%b%b required 01", out_valid32, in_ready32);
    end
  endtask

  task automatic test_backpressure();
    int unsigned w;
    randomize_keys32();
    out_ready32 = 1'b0;
    send32(rand128(), 1'b0, w);
    for (int i = 0; i < 10; i++) begin
      in_valid32 = 1'b1;
      pt_in = rand128();
      tick();
      checks++;
      if ({ct_out32, out_valid32, in_ready32, busy32} !== {last_exp, 3'b100}) begin
        fails++;
        $display("FAIL backpressure_hold_%0d: ct=%h ov/ir/busy=%b%b%b required ct=%h 100",
                 i, ct_out32, out_valid32, in_ready32, busy32, last_exp);
      end
    end
    in_valid32 = 1'b0;
    out_ready32 = 1'b1;
    tick();
    checks++;
    if ({out_valid32, in_ready32} !== 2'b01) begin
      fails++; $display("FAIL backpressure_release: ov/ir=%b%b required 01", out_valid32, in_ready32);
    end
    send32(rand128(), 1'b0, w);
    checks++;
    if (w != 0) begin
      fails++; $display("FAIL backpressure_next_accept: waited %0d cycles required 0", w);
    end
    tick();
  endtask

  task automatic test_round_trip();
    int unsigned  w;
    logic [127:0] pt, rec;
    out_ready32 = 1'b1;
    for (int n = 0; n < 100; n++) begin
      randomize_keys32();
      pt = rand128();
      send32(pt, 1'b0, w);
      rec = model_dec(ct_out32, 32, keys32);
      checks++;
      if (rec !== pt) begin
        fails++; $display("FAIL round_trip_%0d: recovered %h required %h", n, rec, pt);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int unsigned acc, got;
    int unsigned tacc [3];
    logic [127:0] exp;
    randomize_keys32();
    out_ready32 = 1'b1;
    acc = 0;
    got = 0;
    for (int c = 0; c < 300 && got < 3; c++) begin
      if (out_valid32) begin
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        checks++;
        if (ct_out32 !== exp) begin
          fails++; $display("FAIL b2b_ct_%0d: got %h required %h", got, ct_out32, exp);
        end
        got++;
      end
      if (in_ready32 && acc < 3) begin
        pt_in = rand128();
        in_valid32 = 1'b1;
        exp_q.push_back(model_enc(pt_in, 32, keys32));
        tacc[acc] = cyc;
        acc++;
      end else begin
        in_valid32 = 1'b0;
      end
      tick();
    end
    in_valid32 = 1'b0;
    checks++;
    if (got != 3) begin
      fails++; $display("FAIL b2b_outputs: got %0d blocks required 3", got);
    end else begin
      checks++;
      if (tacc[1] - tacc[0] != 35 || tacc[2] - tacc[1] != 35) begin
        fails++;
        $display("FAIL b2b_period: intervals %0d,%0d required 35,35",
                 tacc[1] - tacc[0], tacc[2] - tacc[1]);
      end
    end
  endtask

  task automatic test_reduced_rounds();
    int unsigned  n;
    logic [127:0] exp;
    for (int i = 0; i < 64; i++) keys8[i] = {4{32'(i)}};
    out_ready8 = 1'b1;
    n = 0;
    while (!in_ready8 && n < 100) begin tick(); n++; end
    pt_in = rand128();
    in_valid8 = 1'b1;
    exp_q.push_back(model_enc(pt_in, 8, keys8));
    tick();
    in_valid8 = 1'b0;
    pt_in = rand128();
    repeat (8) tick();
    checks++;
    if ({out_valid8, busy8, key_idx8} !== {2'b01, 6'd8}) begin
      fails++; $display("FAIL reduced_T9: ov/busy/kidx=%b/%b/%0d required 0/1/8", out_valid8, busy8, key_idx8);
    end
    tick();
    checks++;
    if (out_valid8 !== 1'b1) begin
      fails++; $display("FAIL reduced_T10_valid: got %b required 1", out_valid8);
    end
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    checks++;
    if (ct_out8 !== exp) begin
      fails++; $display("FAIL reduced_ct: got %h required %h", ct_out8, exp);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int unsigned w, seen;
    randomize_keys32();
    out_ready32 = 1'b1;
    pt_in = rand128();
    in_valid32 = 1'b1;
    tick();
    in_valid32 = 1'b0;
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready32, busy32, out_valid32} !== 3'b100) begin
      fails++; $display("FAIL reset_mid_state: ir/busy/ov=%b%b%b required 100", in_ready32, busy32, out_valid32);
    end
    seen = 0;
    repeat (40) begin
      if (out_valid32) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      fails++; $display("FAIL reset_mid_no_output: out_valid seen %0d cycles required 0", seen);
    end
    send32(rand128(), 1'b1, w);
    tick();
  endtask

  initial begin
    for (int b = 0; b < 8; b++)
      for (int v = 0; v < 16; v++)
        isb[b][sb[b][v]] = v;
    for (int i = 0; i < 64; i++) begin
      keys32[i] = '0;
      keys8[i]  = '0;
    end
    test_reset();
    test_single_block();
    test_backpressure();
    test_back_to_back();
    test_reduced_rounds();
    test_reset_mid();
    test_round_trip();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
